// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types, constants and helpers
// for the RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN = 32;
  localparam int ITER = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    SEL_LO,
    SEL_HI,
    SEL_QUO,
    SEL_REM
  } sel_e;

  function automatic sel_e sel_of(op_e op);
    sel_e s;
    s = SEL_LO;
    unique case (1'b1)
      op == OP_MUL:           s = SEL_LO;
      !op[2] && op != OP_MUL: s = SEL_HI;
      op[2] && op[1]:         s = SEL_REM;
      default:                s = SEL_QUO;
    endcase
    return s;
  endfunction

  function automatic logic [XLEN-1:0] abs_val(
    logic [XLEN-1:0] v,
    logic            sgn
  );
    return (sgn && v[XLEN-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// muldiv_div_core: restoring divider on magnitudes,
// one quotient bit per step, with sign fix-up on the outputs.
module muldiv_div_core
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic            sgn,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] dvs;
  logic            neg_q;
  logic            neg_r;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;
  logic            ge;

  // shifted < 2*dvs, so the 32-bit difference is exact when ge
  assign shifted = {rem, quo[XLEN-1]};
  assign ge      = shifted >= {1'b0, dvs};
  assign diff    = shifted[XLEN-1:0] - dvs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo   <= '0;
      rem   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (load) begin
      quo   <= abs_val(dividend, sgn);
      rem   <= '0;
      dvs   <= abs_val(divisor, sgn);
      neg_q <= sgn & (dividend[XLEN-1] ^ divisor[XLEN-1]);
      neg_r <= sgn & dividend[XLEN-1];
    end else if (step) begin
      rem <= ge ? diff : shifted[XLEN-1:0];
      quo <= {quo[XLEN-2:0], ge};
    end
  end

  assign quotient  = neg_q ? -quo : quo;
  assign remainder = neg_r ? -rem : rem;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, 33-cycle latency.
// Define MULDIV_DIV_EN to build the divider; otherwise ops 4-7 raise illegal_op.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [4:0]      rd_in,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            illegal_op
);

  state_e          state;
  op_e             op_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [4:0]      rd_q;
  logic [5:0]      cnt;
  logic [XLEN:0]   hi;
  logic            b_neg;

  logic            a_sgn;
  logic [XLEN:0]   a_ext;
  logic [XLEN:0]   addend;
  logic [XLEN+1:0] sum;
  logic [XLEN-1:0] hi_fix;
  logic [XLEN-1:0] mul_res;

  // b_q doubles as the low product half; the multiplier's
  // sign bit is applied once at the end as -a * 2^32
  assign a_sgn   = (op_q == OP_MULH) || (op_q == OP_MULHSU);
  assign a_ext   = {a_sgn & a_q[XLEN-1], a_q};
  assign addend  = b_q[0] ? a_ext : '0;
  assign sum     = {hi[XLEN], hi} + {addend[XLEN], addend};
  assign hi_fix  = hi[XLEN-1:0] - (b_neg ? a_q : '0);
  assign mul_res = (sel_of(op_q) == SEL_LO) ? b_q : hi_fix;

`ifdef MULDIV_DIV_EN
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic            load;
  logic            step;
  logic            by_zero;
  logic            ovf;
  logic            rem_op;

  assign load    = (state == IDLE) && start && !kill && op[2];
  assign step    = (state == DIV) && (cnt != 6'(ITER));
  assign rem_op  = sel_of(op_q) == SEL_REM;
  assign by_zero = b_q == '0;
  assign ovf     = !op_q[0] && (a_q == {1'b1, {(XLEN-1){1'b0}}})
                   && (&b_q);
  assign illegal_op = 1'b0;

  muldiv_div_core u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .step      (step),
    .sgn       (!op[0]),
    .dividend  (operand_a),
    .divisor   (operand_b),
    .quotient  (quo),
    .remainder (rem)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      rd_out <= '0;
      op_q   <= OP_MUL;
      a_q    <= '0;
      b_q    <= '0;
      rd_q   <= '0;
      cnt    <= '0;
      hi     <= '0;
      b_neg  <= 1'b0;
`ifndef MULDIV_DIV_EN
      illegal_op <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifndef MULDIV_DIV_EN
      illegal_op <= 1'b0;
`endif
      if (kill) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            op_q  <= op_e'(op);
            a_q   <= operand_a;
            b_q   <= operand_b;
            rd_q  <= rd_in;
            b_neg <= (op_e'(op) == OP_MULH) && operand_b[XLEN-1];
            hi    <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= op[2] ? DIV : MUL;
          end
          MUL: if (cnt == 6'(ITER)) begin
            result <= mul_res;
            rd_out <= rd_q;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            hi  <= sum[XLEN+1:1];
            b_q <= {sum[0], b_q[XLEN-1:1]};
            cnt <= cnt + 6'd1;
          end
          DIV: begin
`ifdef MULDIV_DIV_EN
            if (cnt == '0 && (by_zero || ovf)) begin
              // overflow quotient equals the dividend itself
              result <= by_zero ? (rem_op ? a_q : '1)
                                : (rem_op ? '0 : a_q);
              rd_out <= rd_q;
              done   <= 1'b1;
              state  <= DONE;
            end else if (cnt == 6'(ITER)) begin
              result <= rem_op ? rem : quo;
              rd_out <= rd_q;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              cnt <= cnt + 6'd1;
            end
`else
            result     <= '0;
            rd_out     <= rd_q;
            done       <= 1'b1;
            illegal_op <= 1'b1;
            state      <= DONE;
`endif
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit.
// Checks results, tags, latency, kill, reset and start-while-busy.
`timescale 1ns/1ps
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic [4:0]  rd_in = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        illegal_op;

  muldiv_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .rd_in      (rd_in),
    .kill       (kill),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .rd_out     (rd_out),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        ill;
    int          t0;
    int          lat;
    string       tag;
  } exp_t;

  exp_t        sbq[$];
  int          cyc = 0;
  int          nchk = 0;
  int          nerr = 0;
  logic [31:0] last_res;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
    nchk++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] o,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sbv;
    logic signed [63:0] ub;
    logic [63:0] p;
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    ub  = {32'b0, b};
    p   = '0;
    case (o)
      3'd0: p = {32'b0, a} * {32'b0, b};
      3'd1: p = sa * sbv;
      3'd2: p = sa * ub;
      3'd3: p = {32'b0, a} * {32'b0, b};
      default: p = '0;
    endcase
    if (o == 3'd0) return p[31:0];
    if (o < 3'd4) return p[63:32];
`ifdef MULDIV_DIV_EN
    if (b == 0) return (o[1]) ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return o[1] ? 32'h0 : a;
    case (o)
      3'd4: return $signed(a) / $signed(b);
      3'd5: return a / b;
      3'd6: return $signed(a) % $signed(b);
      default: return a % b;
    endcase
`else
    return 32'h0;
`endif
  endfunction

  function automatic int lat_of(input logic [2:0] o,
                                input logic [31:0] a,
                                input logic [31:0] b);
    if (o < 3'd4) return 33;
`ifdef MULDIV_DIV_EN
    if (b == 0) return 1;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
`else
    return 1;
`endif
  endfunction

  function automatic logic ill_of(input logic [2:0] o);
`ifdef MULDIV_DIV_EN
    return 1'b0 & o[2];
`else
    return o[2];
`endif
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && sbq.size() == 0) begin
      check("spurious_done", 64'(done), 64'd0);
    end else if (rst_n && done) begin
      e = sbq.pop_front();
      check({e.tag, "_res"}, 64'(result), 64'(e.res));
      check({e.tag, "_rd"}, 64'(rd_out), 64'(e.rd));
      check({e.tag, "_ill"}, 64'(illegal_op), 64'(e.ill));
      check({e.tag, "_lat"}, 64'(cyc - e.t0), 64'(e.lat));
      check({e.tag, "_busy"}, 64'(busy), 64'd1);
    end
  end

  // caller sits at a negedge; start is sampled at the next posedge
  task automatic issue(input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input bit push, input string tag);
    exp_t e;
    op = o;
    operand_a = a;
    operand_b = b;
    rd_in = rd;
    start = 1'b1;
    if (push) begin
      e.res = model(o, a, b);
      e.rd  = rd;
      e.ill = ill_of(o);
      e.t0  = cyc + 1;
      e.lat = lat_of(o, a, b);
      e.tag = tag;
      last_res = e.res;
      sbq.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    if (push) check({tag, "_busy_start"}, 64'(busy), 64'd1);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      check("timeout", 64'(sbq.size()), 64'd0);
      sbq.delete();
    end
  endtask

  task automatic run(input logic [2:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] rd,
                     input string tag);
    @(negedge clk);
    issue(o, a, b, rd, 1'b1, tag);
    drain(60);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    int          n;
    last_res = '0;
    repeat (2) @(negedge clk);
    check("rst_outs",
          64'({busy, done, illegal_op, result, rd_out}), 64'd0);
    rst_n = 1'b1;

    run(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1, "mul");
    run(3'd1, 32'd7, 32'hFFFF_FFFD, 5'd2, "mulh");
    run(3'd3, 32'd7, 32'hFFFF_FFFD, 5'd3, "mulhu");
    run(3'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFD, 5'd4, "mulhsu");
    run(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd5, "mulh_min");
`ifdef MULDIV_DIV_EN
    run(3'd4, 32'hFFFF_FFEC, 32'd6, 5'd6, "div");
    run(3'd6, 32'hFFFF_FFEC, 32'd6, 5'd7, "rem");
    run(3'd5, 32'd100, 32'd7, 5'd8, "divu");
    run(3'd7, 32'd100, 32'd7, 5'd9, "remu");
    run(3'd5, 32'd5, 32'd0, 5'd10, "divu_z");
    run(3'd6, 32'd5, 32'd0, 5'd11, "rem_z");
    run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, "div_ovf");
    run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, "rem_ovf");
`else
    run(3'd4, 32'd9, 32'd3, 5'd6, "div_ill");
    run(3'd0, 32'd3, 32'd3, 5'd7, "mul_after");
`endif

    for (int i = 0; i < 12; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 9));
        default: rb = $urandom;
      endcase
      run(ro, ra, rb, 5'(i + 14), "rand");
    end

    repeat (5) @(negedge clk);
    check("hold_res", 64'(result), 64'(last_res));

    // start during the DONE cycle is dropped
    @(negedge clk);
    issue(3'd0, 32'd5, 32'd6, 5'd3, 1'b1, "pre_done");
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    issue(3'd0, 32'd9, 32'd9, 5'd4, 1'b0, "in_done");
    check("done_start_ign", 64'(busy), 64'd0);
    drain(2);
    repeat (40) @(negedge clk);

    // kill mid-MUL with a simultaneous start
    @(negedge clk);
    issue(3'd0, 32'd12345, 32'd678, 5'd5, 1'b0, "killed");
    repeat (9) @(negedge clk);
    kill = 1'b1;
    start = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    start = 1'b0;
    check("kill_idle", 64'(busy), 64'd0);
    issue(3'd0, 32'd11, 32'd13, 5'd9, 1'b1, "after_kill");
    drain(60);

    // kill and start together in IDLE
    @(negedge clk);
    kill = 1'b1;
    start = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    start = 1'b0;
    check("kill_start_idle", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);

    // reset in flight
    @(negedge clk);
`ifdef MULDIV_DIV_EN
    issue(3'd5, 32'd1000, 32'd3, 5'd21, 1'b0, "rst_op");
`else
    issue(3'd0, 32'd1000, 32'd3, 5'd21, 1'b0, "rst_op");
`endif
    repeat (14) @(negedge clk);
    check("pre_rst_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("rst_async",
             64'({busy, done, illegal_op, result, rd_out}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    // second start while busy is ignored
    @(negedge clk);
`ifdef MULDIV_DIV_EN
    issue(3'd7, 32'd1000, 32'd7, 5'd22, 1'b1, "first");
`else
    issue(3'd0, 32'd1000, 32'd7, 5'd22, 1'b1, "first");
`endif
    repeat (4) @(negedge clk);
    issue(3'd0, 32'd2, 32'd2, 5'd23, 1'b0, "second");
    drain(60);
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The ports SHALL be as follows:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse, driven from the EX/MEM mult_start_out
- op  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- operand_a  input  32  rs1 value
- operand_b  input  32  rs2 value
- rd_in  input  5  destination register tag
- kill  input  1  pipeline flush; aborts any operation in flight
- busy  output  1  high while an operation is in flight or in DONE
- done  output  1  one-cycle completion pulse
- result  output  32  result; valid only while done=1
- rd_out  output  5  tag captured at start; valid while done=1
- illegal_op  output  1  one-cycle pulse; present only when the divider is compiled out (REQ-017)

Function
REQ-003 The state machine SHALL have the states IDLE, MUL, DIV and DONE.
REQ-004 In IDLE, with start=1 and kill=0, the block SHALL latch op, operand_a, operand_b and rd_in at the clock edge.
REQ-005 On that edge, ops 0-3 SHALL go to MUL and ops 4-7 SHALL go to DIV, except for the special cases in REQ-010.
REQ-006 MUL SHALL use radix-2 shift-add on a 64-bit product.
- Each operand SHALL be extended to 33 bits first, signed or unsigned per op.
- The operation SHALL run exactly 32 iterations, then enter DONE.
REQ-007 DIV SHALL use restoring division on absolute values for 32 iterations, then enter DONE.
- The quotient SHALL be negated when the operand signs differ (signed ops only).
- The remainder SHALL take the dividend's sign.
REQ-008 Latency SHALL be exactly 33 cycles: start sampled at edge 0, iterations at edges 1-32, done high in the cycle after edge 33.
REQ-009 Result selection SHALL be:
- MUL: product[31:0]
- MULH, MULHSU, MULHU: product[63:32]
- DIV, DIVU: quotient
- REM, REMU: remainder
REQ-010 The divider special cases SHALL bypass iteration and go to DONE at edge 1 (done in the cycle after edge 1):
- Divide by zero: quotient 0xFFFFFFFF, remainder = operand_a.
- DIV/REM with 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
REQ-011 DONE SHALL last exactly one cycle, then the block SHALL return to IDLE.
- done=1 only in DONE.
- result and rd_out SHALL hold the last values until the next DONE.
REQ-012 A start asserted while busy=1 SHALL be ignored; there is no queueing.
REQ-013 A start asserted in the DONE cycle SHALL be ignored; the earliest accepted start is the cycle after done.
REQ-014 kill=1 in MUL, DIV or DONE SHALL force IDLE at the next edge.
- done SHALL be 0 from that edge onward.
- No result from the aborted operation SHALL be reported.
REQ-015 If kill=1 and start=1 in the same IDLE cycle, kill SHALL win and the request SHALL be dropped.

Reset
REQ-016 While rst_n=0 the block SHALL asynchronously be held as follows:
- state=IDLE, busy=0, done=0, illegal_op=0
- result=0, rd_out=0
- iteration counter, accumulator and latched operands = 0
- An operation interrupted by reset SHALL never produce done.

Configuration
REQ-017 Macro MULDIV_DIV_EN SHALL select whether the divider is built.
- Defined: DIV state and REQ-007/REQ-010 are built; illegal_op is tied to 0.
- Undefined: no divider logic. An accepted op 4-7 SHALL go to DONE at edge 1 with result=0, and illegal_op=1 in that same cycle. MUL ops are unaffected.

Structure
REQ-018 Package muldiv_pkg SHALL contain:
- XLEN=32 and ITER=32
- op enum (funct3 encodings)
- state enum {IDLE, MUL, DIV, DONE}
- result-select helper constants
REQ-019 The divider datapath SHALL be a sub-module, muldiv_div_core, instantiated only under MULDIV_DIV_EN.
- It SHALL contain the remainder/quotient shift registers and the sign fix-up.
- The top-level FSM SHALL drive it with a per-iteration step enable.

Verification
REQ-020 MUL 7 x -3 (0x00000007, 0xFFFFFFFD) -> done at cycle 33, result=0xFFFFFFEB; MULH same operands -> 0xFFFFFFFF; MULHU -> 0x00000006.
REQ-021 DIV -20 / 6 -> quotient 0xFFFFFFFD; REM -> 0xFFFFFFFE; DIVU 100/7 -> 14; REMU -> 2; each with done exactly at cycle 33.
REQ-022 DIVU 5/0 -> done at cycle 1, result 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
REQ-023 Start MUL, pulse kill at cycle 10, assert start again at cycle 10 -> no done; IDLE at cycle 11; a start at cycle 11 completes normally with the correct rd_out.
REQ-024 Start DIV, drop rst_n at cycle 15 -> all outputs 0 immediately; no done after rst_n returns high; a second start while busy is ignored (single done, first operands' result).
REQ-025 With MULDIV_DIV_EN undefined, DIV 9/3 -> done and illegal_op both high in cycle 1, result=0; a following MUL 3x3 -> result 9.
